// File: rtl/cc_regwr_decoder_if.sv
// Issue/commit handshake and register-bank drive bundle for cc_regwr_decoder.
interface cc_regwr_decoder_if #(
  parameter int unsigned DATAWIDTH_DECODER_SELECTION = 4,
  parameter int unsigned DATAWIDTH_DECODER_OUT       = 16
);

  logic                                   CC_REGWRDEC_IssueValid_In;
  logic [DATAWIDTH_DECODER_SELECTION-1:0] CC_REGWRDEC_IssueSel_InBUS;
  logic                                   CC_REGWRDEC_IssueAck_Out;
  logic                                   CC_REGWRDEC_IssueNack_Out;
  logic                                   CC_REGWRDEC_CommitValid_In;
  logic [DATAWIDTH_DECODER_SELECTION-1:0] CC_REGWRDEC_CommitSel_InBUS;
  logic                                   CC_REGWRDEC_Direct_In;
  logic                                   CC_REGWRDEC_Flush_In;
  logic                                   CC_REGWRDEC_ErrClr_In;
  logic [DATAWIDTH_DECODER_OUT-1:0]       CC_REGWRDEC_Load_OutBUS;
  logic [DATAWIDTH_DECODER_OUT-1:0]       CC_REGWRDEC_Busy_OutBUS;
  logic [1:0]                             CC_REGWRDEC_ErrCode_OutBUS;

  // Control unit side: issues reservations and commits.
  modport master (
    output CC_REGWRDEC_IssueValid_In,
    output CC_REGWRDEC_IssueSel_InBUS,
    input  CC_REGWRDEC_IssueAck_Out,
    input  CC_REGWRDEC_IssueNack_Out,
    output CC_REGWRDEC_CommitValid_In,
    output CC_REGWRDEC_CommitSel_InBUS,
    output CC_REGWRDEC_Direct_In,
    output CC_REGWRDEC_Flush_In,
    output CC_REGWRDEC_ErrClr_In,
    input  CC_REGWRDEC_Load_OutBUS,
    input  CC_REGWRDEC_Busy_OutBUS,
    input  CC_REGWRDEC_ErrCode_OutBUS
  );

  // Decoder side.
  modport slave (
    input  CC_REGWRDEC_IssueValid_In,
    input  CC_REGWRDEC_IssueSel_InBUS,
    output CC_REGWRDEC_IssueAck_Out,
    output CC_REGWRDEC_IssueNack_Out,
    input  CC_REGWRDEC_CommitValid_In,
    input  CC_REGWRDEC_CommitSel_InBUS,
    input  CC_REGWRDEC_Direct_In,
    input  CC_REGWRDEC_Flush_In,
    input  CC_REGWRDEC_ErrClr_In,
    output CC_REGWRDEC_Load_OutBUS,
    output CC_REGWRDEC_Busy_OutBUS,
    output CC_REGWRDEC_ErrCode_OutBUS
  );

endinterface

// File: rtl/cc_regwr_decoder.sv
// Register-file write-select decoder with a per-register write scoreboard.
// Issue reserves a destination, commit fires one registered load strobe.
module cc_regwr_decoder #(
  parameter int unsigned                     DATAWIDTH_DECODER_SELECTION = 4,
  parameter int unsigned                     DATAWIDTH_DECODER_OUT       = 16,
  parameter int unsigned                     NUM_REGS                    = 14,
  parameter logic [DATAWIDTH_DECODER_OUT-1:0] PROTECT_MASK               = 16'h0001,
  parameter bit                              ACTIVE_LOW                  = 1'b1
) (
  input  logic               CC_REGWRDEC_CLOCK_50,
  input  logic               CC_REGWRDEC_RESET_InHigh,
  cc_regwr_decoder_if.slave  bus
);

  localparam int unsigned SEL_W = DATAWIDTH_DECODER_SELECTION;
  localparam int unsigned OUT_W = DATAWIDTH_DECODER_OUT;

  localparam logic [OUT_W-1:0] LOAD_IDLE = ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_PROT  = 2'b10;
  localparam logic [1:0] ERR_HAZ   = 2'b11;

  // One-hot decode; selects beyond the load-line count decode to zero.
  function automatic logic [OUT_W-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    logic [OUT_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      if (SEL_W'(i) == sel) v[i] = 1'b1;
    end
    return v;
  endfunction

  logic             clk;
  logic             rst;
  assign clk = CC_REGWRDEC_CLOCK_50;
  assign rst = CC_REGWRDEC_RESET_InHigh;

  logic [OUT_W-1:0] r_busy;
  logic [OUT_W-1:0] r_load;
  logic             r_ack;
  logic             r_nack;
  logic [1:0]       r_err;

  logic [OUT_W-1:0] w_iss_oh;
  logic             w_iss_oor;
  logic             w_iss_prot;
  logic             w_iss_busy;
  logic             w_iss_ok;
  logic [1:0]       w_iss_err;

  logic [OUT_W-1:0] w_cmt_oh;
  logic             w_cmt_oor;
  logic             w_cmt_prot;
  logic             w_cmt_busy;
  logic             w_cmt_ok;
  logic [1:0]       w_cmt_err;

  logic [OUT_W-1:0] w_busy_nxt;
  logic [1:0]       w_new_err;

  // Issue-side legality and reject cause, checked against pre-edge Busy.
  always_comb begin
    w_iss_oh   = sel_onehot(bus.CC_REGWRDEC_IssueSel_InBUS);
    w_iss_oor  = 32'(bus.CC_REGWRDEC_IssueSel_InBUS) >= NUM_REGS;
    w_iss_prot = |(PROTECT_MASK & w_iss_oh);
    w_iss_busy = |(r_busy & w_iss_oh);
    w_iss_ok   = 1'b0;
    w_iss_err  = ERR_NONE;
    if (bus.CC_REGWRDEC_IssueValid_In) begin
      if (w_iss_oor)       w_iss_err = ERR_RANGE;
      else if (w_iss_prot) w_iss_err = ERR_PROT;
      else if (w_iss_busy) w_iss_err = ERR_HAZ;
      else                 w_iss_ok  = 1'b1;
    end
  end

  // Commit-side legality; Direct skips the reservation requirement.
  always_comb begin
    w_cmt_oh   = sel_onehot(bus.CC_REGWRDEC_CommitSel_InBUS);
    w_cmt_oor  = 32'(bus.CC_REGWRDEC_CommitSel_InBUS) >= NUM_REGS;
    w_cmt_prot = |(PROTECT_MASK & w_cmt_oh);
    w_cmt_busy = |(r_busy & w_cmt_oh);
    w_cmt_ok   = 1'b0;
    w_cmt_err  = ERR_NONE;
    if (bus.CC_REGWRDEC_CommitValid_In) begin
      if (w_cmt_oor)                                        w_cmt_err = ERR_RANGE;
      else if (w_cmt_prot)                                  w_cmt_err = ERR_PROT;
      else if (!bus.CC_REGWRDEC_Direct_In && !w_cmt_busy)   w_cmt_err = ERR_HAZ;
      else                                                  w_cmt_ok  = 1'b1;
    end
  end

  // Scoreboard update: flush, then commit release, then issue reservation wins.
  always_comb begin
    w_busy_nxt = bus.CC_REGWRDEC_Flush_In ? '0 : r_busy;
    if (w_cmt_ok) w_busy_nxt = w_busy_nxt & ~w_cmt_oh;
    if (w_iss_ok) w_busy_nxt = w_busy_nxt | w_iss_oh;
    w_new_err = (w_iss_err != ERR_NONE) ? w_iss_err : w_cmt_err;
  end

  // Registered outputs: scoreboard, strobes, handshake pulses, sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
      r_load <= LOAD_IDLE;
      r_ack  <= 1'b0;
      r_nack <= 1'b0;
      r_err  <= ERR_NONE;
    end else begin
      r_busy <= w_busy_nxt;
      r_load <= w_cmt_ok ? (LOAD_IDLE ^ w_cmt_oh) : LOAD_IDLE;
      r_ack  <= w_iss_ok;
      r_nack <= bus.CC_REGWRDEC_IssueValid_In && !w_iss_ok;
      if ((w_new_err != ERR_NONE) && ((r_err == ERR_NONE) || bus.CC_REGWRDEC_ErrClr_In))
        r_err <= w_new_err;
      else if (bus.CC_REGWRDEC_ErrClr_In)
        r_err <= ERR_NONE;
    end
  end

  assign bus.CC_REGWRDEC_Load_OutBUS    = r_load;
  assign bus.CC_REGWRDEC_Busy_OutBUS    = r_busy;
  assign bus.CC_REGWRDEC_IssueAck_Out   = r_ack;
  assign bus.CC_REGWRDEC_IssueNack_Out  = r_nack;
  assign bus.CC_REGWRDEC_ErrCode_OutBUS = r_err;

endmodule

// File: doc/cc_regwr_decoder.md
Name: cc_regwr_decoder

Overview:
Registered, parametrised register-file write-select decoder with a per-register write scoreboard. An issue port reserves a destination register. A commit port later fires exactly one load strobe for that register. Illegal, protected or hazardous requests are rejected and flagged. The block sits between the control unit and the register bank (g0-g7, PC, Temp0-3, IR), driving the per-register load lines.

Parameters:
- DATAWIDTH_DECODER_SELECTION, 4, select width.
- DATAWIDTH_DECODER_OUT, 16, number of load lines; must be at most 2^SELECTION.
- NUM_REGS, 14, selects >= NUM_REGS are out-of-range (14..15 unused).
- PROTECT_MASK, 16'h0001, bit i=1 means register i is never writable (g0).
- ACTIVE_LOW, 1, 1: load lines are active-low (idle all ones); 0: active-high.

Ports:
- CC_REGWRDEC_CLOCK_50 input 1: system clock, rising edge.
- CC_REGWRDEC_RESET_InHigh input 1: reset, asynchronous, active-high.
- CC_REGWRDEC_IssueValid_In input 1: reserve request.
- CC_REGWRDEC_IssueSel_InBUS input SELECTION: register to reserve.
- CC_REGWRDEC_IssueAck_Out output 1: one-cycle pulse, reservation accepted.
- CC_REGWRDEC_IssueNack_Out output 1: one-cycle pulse, reservation rejected.
- CC_REGWRDEC_CommitValid_In input 1: write-back request.
- CC_REGWRDEC_CommitSel_InBUS input SELECTION: register to load.
- CC_REGWRDEC_Direct_In input 1: 1 means commit bypasses the scoreboard.
- CC_REGWRDEC_Flush_In input 1: synchronous clear of all reservations.
- CC_REGWRDEC_ErrClr_In input 1: clears the error code.
- CC_REGWRDEC_Load_OutBUS output OUT: per-register load strobes (registered).
- CC_REGWRDEC_Busy_OutBUS output OUT: scoreboard, bit i=1 means register i is reserved.
- CC_REGWRDEC_ErrCode_OutBUS output 2: 00 none, 01 out-of-range, 10 protected, 11 hazard.

Behaviour:
- Reset (async, any time, including mid-operation): Load=idle (all ones if ACTIVE_LOW, else zeros); Busy=0; Ack=Nack=0; ErrCode=00. Pending reservations are discarded.
- "Legal sel": sel < NUM_REGS and PROTECT_MASK[sel]=0.
- Issue, evaluated against pre-edge Busy:
  - Legal sel and Busy[sel]=0: next edge sets Busy[sel] and pulses Ack for 1 cycle.
  - Otherwise: pulses Nack for 1 cycle and Busy is unchanged.
  - Reject cause priority: out-of-range (01) > protected (10) > busy (11).
- Commit, Direct=0:
  - Legal sel and Busy[sel]=1: next cycle Load bit sel is active for exactly 1 cycle; Busy[sel] clears at the same edge.
  - Busy[sel]=0 or illegal sel: no strobe; error logged (11, or 01/10 for illegal sel).
- Commit, Direct=1:
  - Legal sel: strobe 1 cycle later regardless of Busy; Busy[sel] clears if set.
  - Illegal sel: no strobe; error logged.
- Latency: Issue to Ack/Nack is 1 cycle; Commit to Load is 1 cycle. Load is idle in every other cycle, and at most one Load bit is active per cycle.
- Back-to-back commits on consecutive cycles produce strobes on consecutive cycles.
- Simultaneous issue and commit, same sel: commit takes effect (strobe, clear). Issue sees pre-edge Busy=1, so it is Nacked with code 11. The requester retries.
- Simultaneous issue and commit, different sel: both processed independently in the same cycle.
- Flush: next edge clears all Busy bits. A same-cycle commit still strobes if legal and (Busy or Direct). A same-cycle issue is evaluated normally, and its Busy bit is set after the flush (issue wins over flush).
- ErrCode is sticky: only the first error after clear is latched, and later errors do not overwrite it.
  - ErrClr sets 00 at the next edge.
  - An error in the same cycle as ErrClr is latched (error wins).
  - If issue and commit both err in one cycle, the issue cause is latched.
- All outputs are registered, with no combinational input-to-output path.

Test Plan:
1. Assert reset mid-reservation (Busy=16'h0008) -> asynchronously Load=16'hFFFF, Busy=16'h0000, ErrCode=00, Ack=Nack=0.
2. Issue sel=3 -> next cycle Ack=1, Busy=16'h0008. Commit sel=3 -> next cycle Load=16'hFFF7 for one cycle, then 16'hFFFF; Busy=16'h0000.
3. Issue sel=0 -> Nack=1, ErrCode=10, Busy unchanged. Then issue sel=14 -> Nack, ErrCode stays 10. ErrClr, then issue sel=14 -> ErrCode=01.
4. Issue sel=5 twice (cycles n, n+1) -> Ack at n+1, Nack at n+2, ErrCode=11. Then commit sel=5 plus issue sel=5 in the same cycle -> Load=16'hFFDF, Nack, Busy=0.
5. Direct=1, commit sel=8 with Busy=0 -> Load=16'hFEFF for one cycle, ErrCode unchanged. Direct=0, commit sel=8 -> no strobe, ErrCode=11.
6. Busy=16'h0306 (sel 1,2,8,9 reserved), then Flush plus issue sel=4 -> Busy=16'h0010. Then commit sel=2 -> no strobe, ErrCode=11.
